// File: rtl/wr_ctrl_param_if.sv
// Signal bundle between the FIFO write-side controller and its neighbours:
// read-pointer input, active-low request, RAM write port and status flags.
interface wr_ctrl_param_if #(
    parameter int ADDR_W = 3
) ();
    logic [ADDR_W:0]   rd_ptr_g;
    logic              wr_req_;
    logic              ovf_clr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   wr_ptr_g;
    logic [ADDR_W:0]   wr_count;
    logic              full;
    logic              almost_full;
    logic              ovf;

    modport slave (
        input  rd_ptr_g, wr_req_, ovf_clr,
        output wr_en, wr_addr, wr_ptr_g, wr_count, full, almost_full, ovf
    );

    modport master (
        output rd_ptr_g, wr_req_, ovf_clr,
        input  wr_en, wr_addr, wr_ptr_g, wr_count, full, almost_full, ovf
    );
endinterface

// File: rtl/wr_ctrl_param.sv
// Write-side controller of a dual-clock gray-pointer FIFO with occupancy, almost-full
// and full flags. Define WR_CTRL_OVF_EN to build the sticky overflow flag.
module wr_ctrl_param #(
    parameter int ADDR_W   = 3,
    parameter int SYNC_DLY = 2,
    parameter int AF_LEVEL = 6
) (
    input logic            wr_clk,
    input logic            rst_,
    wr_ctrl_param_if.slave bus
);
    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PTR_W:0]   DEPTH_X = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] AF_THR  = PTR_W'(AF_LEVEL);

    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [PTR_W-1:0] sync_q [SYNC_DLY];
    logic [PTR_W-1:0] wr_ptr_b_q, wr_ptr_b_d;
    logic [PTR_W-1:0] wr_ptr_g_q, wr_ptr_g_d;
    logic             wr_en_q, wr_en_d;

    logic [PTR_W-1:0] rd_bin;
    logic [PTR_W-1:0] used;
    logic [PTR_W:0]   used_pend;
    logic             accept;
    logic             full_w;

    // Read pointer enters wr_clk raw; the first stage must see nothing but the bus.
    // NOTE: every synchroniser stage is reset so full/count are defined straight
    // out of reset, even though this is a register array.
    always_ff @(posedge wr_clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < SYNC_DLY; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.rd_ptr_g;
            for (int i = 1; i < SYNC_DLY; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Occupancy is wrap-bit arithmetic on registered values only; the write that
    // is already strobing but not yet counted in wr_ptr_b must still reserve a slot.
    // NOTE: combinational logic uses blocking '=' with every output defaulted first,
    // so no latch can be inferred; state below is updated with non-blocking '<='.
    always_comb begin
        rd_bin     = gray2bin(sync_q[SYNC_DLY-1]);
        used       = wr_ptr_b_q - rd_bin;
        used_pend  = {1'b0, used} + {{PTR_W{1'b0}}, wr_en_q};
        accept     = !bus.wr_req_ && (used_pend < DEPTH_X);
        full_w     = (wr_ptr_b_q[ADDR_W] != rd_bin[ADDR_W]) &&
                     (wr_ptr_b_q[ADDR_W-1:0] == rd_bin[ADDR_W-1:0]);
        wr_en_d    = accept;
        wr_ptr_b_d = wr_ptr_b_q + {{ADDR_W{1'b0}}, wr_en_q};
        wr_ptr_g_d = bin2gray(wr_ptr_b_d);
    end

    // Gray pointer is registered so the read side never sees a multi-bit glitch.
    always_ff @(posedge wr_clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr_b_q <= '0;
            wr_ptr_g_q <= '0;
            wr_en_q    <= 1'b0;
        end else begin
            wr_ptr_b_q <= wr_ptr_b_d;
            wr_ptr_g_q <= wr_ptr_g_d;
            wr_en_q    <= wr_en_d;
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_ptr_b_q[ADDR_W-1:0];
    assign bus.wr_ptr_g    = wr_ptr_g_q;
    assign bus.wr_count    = used;
    assign bus.full        = full_w;
    assign bus.almost_full = (used >= AF_THR);

`ifdef WR_CTRL_OVF_EN
    logic ovf_q, ovf_d;

    // Clear beats a same-cycle refused request.
    always_comb begin
        ovf_d = ovf_q;
        if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end else if (!bus.wr_req_ && !accept && full_w) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge wr_clk or negedge rst_) begin
        if (!rst_) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = bus.ovf_clr;
    assign bus.ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_wr_ctrl_param.sv
// Randomised self-checking bench for wr_ctrl_param against a counter-level model
// (total writes, total reads, delayed view of the read count).
module tb_wr_ctrl_param;
    localparam int ADDR_W   = 3;
    localparam int SYNC_DLY = 2;
    localparam int AF_LEVEL = 6;
    localparam int PTR_W    = ADDR_W + 1;
    localparam int DEPTH    = 1 << ADDR_W;
`ifdef WR_CTRL_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic wr_clk = 1'b0;
    logic rst_;
    always #5 wr_clk = ~wr_clk;

    wr_ctrl_param_if #(.ADDR_W(ADDR_W)) bus ();

    wr_ctrl_param #(
        .ADDR_W  (ADDR_W),
        .SYNC_DLY(SYNC_DLY),
        .AF_LEVEL(AF_LEVEL)
    ) dut (
        .wr_clk(wr_clk),
        .rst_  (rst_),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: total committed writes, pending strobe, total reads, read history per edge.
    int m_wr;
    bit m_pend;
    int rd_cnt;
    bit m_ovf;
    int hist[$];

    function automatic logic [PTR_W-1:0] to_gray(input int v);
        logic [PTR_W-1:0] b;
        b = PTR_W'(v);
        return b ^ (b >> 1);
    endfunction

    function automatic int seen_rd();
        return hist[hist.size() - SYNC_DLY];
    endfunction

    function automatic int exp_used();
        return m_wr - seen_rd();
    endfunction

    task automatic model_reset();
        m_wr   = 0;
        m_pend = 1'b0;
        rd_cnt = 0;
        m_ovf  = 1'b0;
        hist.delete();
        for (int i = 0; i < SYNC_DLY; i++) hist.push_back(0);
    endtask

    // One wr_clk cycle: drive at negedge, advance the model at posedge, return at posedge+1.
    task automatic tick(input logic req_n, input logic clr);
        int  used;
        bit  acc;
        @(negedge wr_clk);
        bus.wr_req_  = req_n;
        bus.ovf_clr  = clr;
        bus.rd_ptr_g = to_gray(rd_cnt);
        @(posedge wr_clk);
        used = exp_used();
        acc  = !req_n && (used + int'(m_pend) < DEPTH);
        if (OVF_EN) begin
            if (clr) m_ovf = 1'b0;
            else if (!req_n && !acc && used == DEPTH) m_ovf = 1'b1;
        end
        m_wr   = m_wr + int'(m_pend);
        m_pend = acc;
        hist.push_back(rd_cnt);
        if (hist.size() > 16) void'(hist.pop_front());
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        checks++;
        if (bus.wr_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_prewrite: wr_en got %b want 1", bus.wr_en);
        end
        #1 rst_ = 1'b0;
        #1;
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_ptr_g, bus.wr_count, bus.full,
             bus.almost_full, bus.ovf} !== '0) begin
            errors++;
            $display("FAIL reset_async: en=%b addr=%0d g=%b cnt=%0d full=%b af=%b ovf=%b want all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_ptr_g, bus.wr_count, bus.full,
                     bus.almost_full, bus.ovf);
        end
        @(negedge wr_clk);
        bus.wr_req_  = 1'b1;
        bus.rd_ptr_g = '0;
        rst_ = 1'b1;
        model_reset();
        tick(1'b1, 1'b0);
        checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_ptr_g !== '0 || bus.wr_count !== '0) begin
            errors++;
            $display("FAIL reset_dropped: en=%b g=%b cnt=%0d want 0/0/0",
                     bus.wr_en, bus.wr_ptr_g, bus.wr_count);
        end
    endtask

    task automatic test_fill_almost_full();
        int pulses = 0;
        bit af_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0);
            if (bus.wr_en === 1'b1) begin
                checks++;
                if (bus.wr_addr !== ADDR_W'(pulses)) begin
                    errors++;
                    $display("FAIL fill_addr: got %0d want %0d", bus.wr_addr, pulses);
                end
                pulses++;
            end
            if (m_wr == AF_LEVEL && !af_seen) begin
                af_seen = 1'b1;
                checks++;
                if (bus.almost_full !== 1'b1 || bus.full !== 1'b0 ||
                    bus.wr_count !== PTR_W'(AF_LEVEL)) begin
                    errors++;
                    $display("FAIL almost_full: af=%b full=%b cnt=%0d want 1/0/%0d",
                             bus.almost_full, bus.full, bus.wr_count, AF_LEVEL);
                end
            end
        end
        checks++;
        if (pulses != DEPTH || !af_seen) begin
            errors++;
            $display("FAIL fill_pulses: got %0d want %0d (af_seen=%b)", pulses, DEPTH, af_seen);
        end
        checks++;
        if (bus.full !== 1'b1 || bus.wr_count !== 4'd8 || bus.wr_ptr_g !== 4'b1100) begin
            errors++;
            $display("FAIL fill_final: full=%b cnt=%0d g=%b want 1/8/1100",
                     bus.full, bus.wr_count, bus.wr_ptr_g);
        end
    endtask

    task automatic test_release();
        rd_cnt = 1;
        tick(1'b0, 1'b0);
        checks++;
        if (bus.full !== 1'b1) begin
            errors++;
            $display("FAIL release_edge1: full got %b want 1", bus.full);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (bus.full !== 1'b0 || bus.wr_count !== 4'd7) begin
            errors++;
            $display("FAIL release_edge2: full=%b cnt=%0d want 0/7", bus.full, bus.wr_count);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'd0) begin
            errors++;
            $display("FAIL release_write: en=%b addr=%0d want 1/0", bus.wr_en, bus.wr_addr);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (bus.full !== 1'b1 || bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL release_refull: full=%b en=%b want 1/0", bus.full, bus.wr_en);
        end
    endtask

    task automatic test_wrap();
        logic [PTR_W-1:0] prev_g;
        bit saw_wrap = 1'b0;
        prev_g = bus.wr_ptr_g;
        for (int i = 0; i < 40; i++) begin
            if (rd_cnt < m_wr) rd_cnt++;
            tick(1'b0, 1'b0);
            checks++;
            if (bus.wr_count !== PTR_W'(exp_used()) || exp_used() > DEPTH) begin
                errors++;
                $display("FAIL wrap_count: got %0d want %0d", bus.wr_count, exp_used());
            end
            checks++;
            if (bus.wr_en !== m_pend || (bus.wr_en === 1'b1 && bus.full === 1'b1)) begin
                errors++;
                $display("FAIL wrap_en: en=%b full=%b want en=%b and never both", bus.wr_en,
                         bus.full, m_pend);
            end
            checks++;
            if (bus.wr_ptr_g !== to_gray(m_wr) || $countones(bus.wr_ptr_g ^ prev_g) > 1) begin
                errors++;
                $display("FAIL wrap_gray: got %b prev %b want %b", bus.wr_ptr_g, prev_g,
                         to_gray(m_wr));
            end
            if (prev_g == 4'b1000 && bus.wr_ptr_g !== prev_g) saw_wrap = (bus.wr_ptr_g == 4'b0000);
            prev_g = bus.wr_ptr_g;
        end
        checks++;
        if (!saw_wrap) begin
            errors++;
            $display("FAIL wrap_step: 1000->0000 transition got 0 want 1");
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 12 && bus.full !== 1'b1; i++) tick(1'b0, 1'b0);
        checks++;
        if (bus.full !== 1'b1 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_setup: full=%b ovf=%b want 1/0", bus.full, bus.ovf);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (bus.ovf !== OVF_EN) begin
            errors++;
            $display("FAIL ovf_set: got %b want %b", bus.ovf, OVF_EN);
        end
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        checks++;
        if (bus.ovf !== OVF_EN) begin
            errors++;
            $display("FAIL ovf_hold: got %b want %b", bus.ovf, OVF_EN);
        end
        tick(1'b1, 1'b1);
        checks++;
        if (bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b want 0", bus.ovf);
        end
        tick(1'b0, 1'b1);
        checks++;
        if (bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr_priority: got %b want 0", bus.ovf);
        end
        tick(1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [PTR_W-1:0] prev_g;
        bit req_n, clr;
        prev_g = bus.wr_ptr_g;
        for (int i = 0; i < 400; i++) begin
            req_n = ($urandom_range(0, 3) == 0);
            clr   = ($urandom_range(0, 7) == 0);
            if (rd_cnt < m_wr && $urandom_range(0, 1) == 1) rd_cnt++;
            tick(req_n, clr);
            checks++;
            if (bus.wr_en !== m_pend || (m_pend && bus.wr_addr !== ADDR_W'(m_wr))) begin
                errors++;
                $display("FAIL rand_wr: en=%b addr=%0d want %b/%0d", bus.wr_en, bus.wr_addr,
                         m_pend, m_wr % DEPTH);
            end
            checks++;
            if (bus.wr_count !== PTR_W'(exp_used()) || bus.full !== (exp_used() == DEPTH) ||
                bus.almost_full !== (exp_used() >= AF_LEVEL)) begin
                errors++;
                $display("FAIL rand_flags: cnt=%0d full=%b af=%b want cnt=%0d", bus.wr_count,
                         bus.full, bus.almost_full, exp_used());
            end
            checks++;
            if (bus.wr_ptr_g !== to_gray(m_wr) || $countones(bus.wr_ptr_g ^ prev_g) > 1) begin
                errors++;
                $display("FAIL rand_gray: got %b want %b", bus.wr_ptr_g, to_gray(m_wr));
            end
            checks++;
            if (bus.ovf !== m_ovf) begin
                errors++;
                $display("FAIL rand_ovf: got %b want %b", bus.ovf, m_ovf);
            end
            prev_g = bus.wr_ptr_g;
        end
    endtask

    initial begin
        rst_         = 1'b0;
        bus.wr_req_  = 1'b1;
        bus.ovf_clr  = 1'b0;
        bus.rd_ptr_g = '0;
        model_reset();
        repeat (2) @(negedge wr_clk);
        rst_ = 1'b1;
        test_reset();
        test_fill_almost_full();
        test_release();
        test_wrap();
        test_overflow();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
